// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: request/response sequencer for a 32-bit iterative restoring divider
// that handles DIV/DIVU/REM/REMU with sign correction, kill and backpressure.
module div_seq_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_dived,
    input  logic [XLEN-1:0] in_divor,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
    state_t              r_state, w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_op;
    logic                r_neg_q, r_neg_r;
    logic [2*XLEN-1:0]   r_rem, r_div;
    logic [XLEN-1:0]     r_quo, r_result;
    logic                w_acc, w_sgn, w_dz, w_ovf, w_ge, w_last;
    logic [XLEN-1:0]     w_abs_a, w_abs_b, w_q, w_r;

    always_comb begin
        w_acc   = in_valid & (r_state == IDLE);
        w_sgn   = ~in_op[0];
        w_abs_a = (w_sgn & in_dived[XLEN-1]) ? -in_dived : in_dived;
        w_abs_b = (w_sgn & in_divor[XLEN-1]) ? -in_divor : in_divor;
        w_dz    = in_divor == '0;
        w_ovf   = w_sgn & (in_dived == {1'b1, {(XLEN-1){1'b0}}}) & (&in_divor);
        w_ge    = r_div <= r_rem;
        w_last  = r_cnt == CNT_W'(XLEN-1);
        w_q     = r_neg_q ? -r_quo : r_quo;
        w_r     = r_neg_r ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // kill only matters once an operation is in flight; in IDLE it must not block an accept
    always_comb begin
        w_next = (r_state != IDLE && kill) ? IDLE :
                 (r_state == IDLE) ? (w_acc ? ((w_dz | w_ovf) ? DONE : CALC) : IDLE) :
                 (r_state == CALC) ? (w_last ? SIGN : CALC) :
                 (r_state == SIGN) ? DONE :
                 (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_rem    <= '0;
            r_div    <= '0;
            r_quo    <= '0;
            r_result <= '0;
        end else begin
            if (w_acc) begin
                r_op    <= in_op;
                r_neg_q <= w_sgn & (in_dived[XLEN-1] ^ in_divor[XLEN-1]);
                r_neg_r <= w_sgn & in_dived[XLEN-1];
                r_cnt   <= '0;
                r_quo   <= '0;
                r_rem   <= {{XLEN{1'b0}}, w_abs_a};
                r_div   <= {1'b0, w_abs_b, {(XLEN-1){1'b0}}};
                if (w_dz | w_ovf)
                    r_result <= in_op[1] ? (w_dz ? in_dived : '0) : (w_dz ? '1 : in_dived);
            end
            // quotient bits enter at the LSB and reach their final position after XLEN shifts
            if (r_state == CALC) begin
                r_rem <= w_ge ? r_rem - r_div : r_rem;
                r_quo <= {r_quo[XLEN-2:0], w_ge};
                r_div <= r_div >> 1;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == SIGN) r_result <= r_op[1] ? w_r : w_q;
        end
    end

    always_comb begin
        in_ready   = r_state == IDLE;
        out_valid  = r_state == DONE;
        busy       = r_state != IDLE;
        out_result = r_result;
    end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed and random checks of div_seq_ctrl against an arithmetic
// reference model of the divide results and their latency.
module tb_div_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, kill, out_valid, out_ready, busy;
    logic [1:0]  in_op;
    logic [31:0] in_dived, in_divor, out_result;
    int          errors = 0;
    int          checks = 0;

    div_seq_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_dived(in_dived), .in_divor(in_divor), .kill(kill), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, output int lat);
        logic [31:0] q, r;
        lat = 33;
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a; lat = 1;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 0; lat = 1;
        end else if (!op[0]) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b; r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    // Issues one request, checks latency and result, scrambles inputs after accept, then drains it.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int lat, n;
        logic [31:0] exp;
        exp = model(op, a, b, lat);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = op; in_dived = a; in_divor = b;
        step();
        in_valid = 1'b0; in_op = 2'($urandom); in_dived = $urandom; in_divor = $urandom;
        n = 0;
        do begin
            step();
            n++;
        end while (!out_valid && n < 100);
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_result"}, out_result, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_release"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        int n, lat;
        logic seen;
        logic [1:0]  op;
        logic [31:0] a, b;
        rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
        in_op = 2'b00; in_dived = '0; in_divor = '0;
        step(); step();
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", out_result, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();

        run_op("divu_100_7", 2'b01, 32'd100, 32'd7);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7);
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE);
        run_op("divu_by0", 2'b01, 32'h1234_5678, 32'd0);
        run_op("remu_by0", 2'b11, 32'h1234_5678, 32'd0);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("model_div_m7_2", model(2'b00, 32'hFFFF_FFF9, 32'd2, lat), 32'hFFFF_FFFD);

        // backpressure in DONE
        in_valid = 1'b1; in_op = 2'b01; in_dived = 32'hFFFF_FFFF; in_divor = 32'd1;
        step();
        in_valid = 1'b0;
        n = 0;
        do begin step(); n++; end while (!out_valid && n < 100);
        chk("bp_latency", 32'(n), 32'd33);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold", {29'd0, out_valid, in_ready, busy}, 32'b101);
            chk("bp_result", out_result, 32'hFFFF_FFFF);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release", {30'd0, in_ready, busy}, 32'b10);

        // kill in IDLE must not block the accept; kill mid-CALC aborts
        kill = 1'b1; in_valid = 1'b1; in_op = 2'b01; in_dived = 32'd1000; in_divor = 32'd3;
        step();
        kill = 1'b0; in_valid = 1'b0;
        chk("kill_idle_accept", {30'd0, busy, in_ready}, 32'b10);
        for (int i = 0; i < 15; i++) step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("kill_to_idle", {29'd0, in_ready, busy, out_valid}, 32'b100);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            seen |= out_valid;
        end
        chk("kill_no_result", 32'(seen), 32'd0);
        run_op("divu_9_3", 2'b01, 32'd9, 32'd3);

        // kill wins over out_ready in DONE
        in_valid = 1'b1; in_op = 2'b01; in_dived = 32'd5; in_divor = 32'd0;
        step();
        in_valid = 1'b0;
        step();
        chk("kd_valid", 32'(out_valid), 32'd1);
        kill = 1'b1; out_ready = 1'b1;
        step();
        kill = 1'b0; out_ready = 1'b0;
        chk("kd_idle", {30'd0, in_ready, out_valid}, 32'b10);

        // reset mid-CALC with a request pending
        in_valid = 1'b1; in_op = 2'b00; in_dived = 32'd12345; in_divor = 32'd17;
        step();
        for (int i = 0; i < 20; i++) step();
        chk("rst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
        chk("rst_result", out_result, 32'd0);
        step();
        chk("rst_no_accept", 32'(busy), 32'd0);

        for (int k = 0; k < 24; k++) begin
            op = 2'($urandom);
            a  = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 20);
                3:       b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run_op($sformatf("rand%0d", k), op, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
